// File: rtl/rat_int_pkg.sv
// Shared types and register map for the RAT MCU interrupt controller.
package rat_int_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ID_W   = 3;

  localparam int unsigned OFS_MASK  = 0;
  localparam int unsigned OFS_PEND  = 1;
  localparam int unsigned OFS_CAUSE = 2;
  localparam int unsigned OFS_EOI   = 3;

  localparam int unsigned CAUSE_VALID_BIT = 7;
  localparam int unsigned CAUSE_ID_LSB    = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

  // CAUSE register layout: {INS_VALID, reserved, source id}
  typedef struct packed {
    logic            ins_valid;
    logic [3:0]      rsvd;
    logic [ID_W-1:0] id;
  } cause_t;

  function automatic logic [DATA_W-1:0] port_addr(input logic [DATA_W-1:0] base,
                                                  input int unsigned      ofs);
    return base + DATA_W'(ofs);
  endfunction

endpackage

// File: rtl/rat_int_prio_enc.sv
// Fixed-priority encoder: lowest set index wins, reported as {valid, id}.
module rat_int_prio_enc
  import rat_int_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]    req,
  output logic            valid,
  output logic [ID_W-1:0] id
);

  // Scan high to low so the last hit, the lowest index, is kept.
  always_comb begin
    valid = 1'b0;
    id    = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        id    = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/rat_int_ctrl.sv
// RAT MCU interrupt controller: edge-latched pending bits, fixed priority, EOI handshake.
// Define RAT_INT_SYNC_EN to pass IRQ through a two-flop synchronizer before edge detect.
module rat_int_ctrl
  import rat_int_pkg::*;
#(
  parameter int unsigned        N_SRC   = 8,
  parameter logic [DATA_W-1:0]  BASE_ID = 8'hE0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [N_SRC-1:0]  IRQ,
  input  logic              INT_ACK,
  input  logic [DATA_W-1:0] PORT_ID,
  input  logic [DATA_W-1:0] OUT_PORT,
  input  logic              IO_STRB,
  output logic              INT_CU,
  output logic [DATA_W-1:0] IN_DATA,
  output logic              RD_HIT
);

  localparam logic [DATA_W-1:0] ADDR_MASK  = port_addr(BASE_ID, OFS_MASK);
  localparam logic [DATA_W-1:0] ADDR_PEND  = port_addr(BASE_ID, OFS_PEND);
  localparam logic [DATA_W-1:0] ADDR_CAUSE = port_addr(BASE_ID, OFS_CAUSE);
  localparam logic [DATA_W-1:0] ADDR_EOI   = port_addr(BASE_ID, OFS_EOI);

  state_e           state_q, state_d;
  cause_t           cause_q, cause_d;
  logic [N_SRC-1:0] mask_q, pend_q, irq_q, irq_s, irq_new;
  logic [N_SRC-1:0] w1c, ack_clr, src_sel;
  logic             mask_wr, eoi_wr, take, src_live;
  logic             win_valid;
  logic [ID_W-1:0]  win_id;

`ifdef RAT_INT_SYNC_EN
  logic [N_SRC-1:0] sync1_q, sync2_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= IRQ;
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = IRQ;
`endif

  assign irq_new = irq_s & ~irq_q;
  assign mask_wr = IO_STRB && (PORT_ID == ADDR_MASK);
  assign eoi_wr  = IO_STRB && (PORT_ID == ADDR_EOI);
  assign w1c     = (IO_STRB && (PORT_ID == ADDR_PEND)) ? OUT_PORT[N_SRC-1:0] : '0;

  rat_int_prio_enc #(.N(N_SRC)) u_prio (
    .req   (pend_q & mask_q),
    .valid (win_valid),
    .id    (win_id)
  );

  // One-hot of the latched source; used to check it is still live and to clear it on ACK.
  always_comb begin
    src_sel = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      src_sel[i] = (cause_q.id == ID_W'(i));
    end
  end

  assign src_live = |(src_sel & pend_q & mask_q);
  assign ack_clr  = take ? src_sel : '0;

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    take    = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          cause_d.id = win_id;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (!src_live) begin
          state_d = IDLE;
        end else if (INT_ACK) begin
          take              = 1'b1;
          cause_d.ins_valid = 1'b1;
          state_d           = SERVICE;
        end
      end
      SERVICE: begin
        if (eoi_wr) begin
          cause_d.ins_valid = 1'b0;
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // INT_CU asserts one cycle into REQ and drops on the edge that leaves REQ.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      cause_q <= '0;
      mask_q  <= '0;
      pend_q  <= '0;
      irq_q   <= '0;
      INT_CU  <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      irq_q   <= irq_s;
      pend_q  <= (pend_q & ~w1c & ~ack_clr) | irq_new;
      INT_CU  <= (state_q == REQ) && (state_d == REQ);
      if (mask_wr) begin
        mask_q <= OUT_PORT[N_SRC-1:0];
      end
    end
  end

  always_comb begin
    IN_DATA = '0;
    RD_HIT  = 1'b0;
    if (PORT_ID == ADDR_MASK) begin
      RD_HIT  = 1'b1;
      IN_DATA = DATA_W'(mask_q);
    end else if (PORT_ID == ADDR_PEND) begin
      RD_HIT  = 1'b1;
      IN_DATA = DATA_W'(pend_q);
    end else if (PORT_ID == ADDR_CAUSE) begin
      RD_HIT  = 1'b1;
      IN_DATA = cause_q;
    end
  end

endmodule

// File: tb/tb_rat_int_ctrl.sv
// Directed self-checking bench for rat_int_ctrl.
module tb_rat_int_ctrl;

`ifdef RAT_INT_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  localparam logic [7:0] A_MASK  = 8'hE0;
  localparam logic [7:0] A_PEND  = 8'hE1;
  localparam logic [7:0] A_CAUSE = 8'hE2;
  localparam logic [7:0] A_EOI   = 8'hE3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] irq;
  logic       int_ack;
  logic [7:0] port_id;
  logic [7:0] out_port;
  logic       io_strb;
  logic       int_cu;
  logic [7:0] in_data;
  logic       rd_hit;

  int n_checks = 0;
  int n_fail   = 0;

  rat_int_ctrl #(.N_SRC(8), .BASE_ID(8'hE0)) dut (
    .CLK      (clk),
    .RESET    (rst_n),
    .IRQ      (irq),
    .INT_ACK  (int_ack),
    .PORT_ID  (port_id),
    .OUT_PORT (out_port),
    .IO_STRB  (io_strb),
    .INT_CU   (int_cu),
    .IN_DATA  (in_data),
    .RD_HIT   (rd_hit)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic io_write(input logic [7:0] id, input logic [7:0] data);
    port_id  = id;
    out_port = data;
    io_strb  = 1'b1;
    tick(1);
    io_strb  = 1'b0;
    port_id  = 8'h00;
    out_port = 8'h00;
  endtask

  task automatic chk_reg(input string tag, input logic [7:0] id, input logic [7:0] exp);
    port_id = id;
    #1;
    check_eq(tag, in_data, exp);
    port_id = 8'h00;
  endtask

  task automatic pulse_irq(input logic [7:0] bits);
    irq = bits;
    tick(1);
    irq = 8'h00;
    tick(SYNC_LAT);
  endtask

  task automatic ack;
    int_ack = 1'b1;
    tick(1);
    int_ack = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    irq      = 8'h00;
    int_ack  = 1'b0;
    port_id  = 8'h00;
    out_port = 8'h00;
    io_strb  = 1'b0;
    tick(3);
    check_eq("rst_int_cu", {7'b0, int_cu}, 8'h00);
    rst_n = 1'b1;
    chk_reg("rst_mask", A_MASK, 8'h00);
    chk_reg("rst_pend", A_PEND, 8'h00);
    chk_reg("rst_cause", A_CAUSE, 8'h00);

    // Basic request on source 0
    io_write(A_MASK, 8'h01);
    pulse_irq(8'h01);
    chk_reg("basic_pend", A_PEND, 8'h01);
    check_eq("basic_cu_lo", {7'b0, int_cu}, 8'h00);
    tick(1);
    check_eq("basic_cu_lo2", {7'b0, int_cu}, 8'h00);
    tick(1);
    check_eq("basic_cu_hi", {7'b0, int_cu}, 8'h01);
    ack();
    chk_reg("basic_cause_ack", A_CAUSE, 8'h80);
    chk_reg("basic_pend_ack", A_PEND, 8'h00);
    check_eq("basic_cu_ack", {7'b0, int_cu}, 8'h00);
    io_write(A_EOI, 8'h5A);
    chk_reg("basic_cause_eoi", A_CAUSE, 8'h00);
    tick(3);
    check_eq("basic_cu_idle", {7'b0, int_cu}, 8'h00);

    // Reset in the middle of a service
    pulse_irq(8'h01);
    tick(2);
    ack();
    chk_reg("svc_cause", A_CAUSE, 8'h80);
    irq   = 8'h01;
    rst_n = 1'b0;
    #1;
    check_eq("mrst_int_cu", {7'b0, int_cu}, 8'h00);
    chk_reg("mrst_mask", A_MASK, 8'h00);
    chk_reg("mrst_cause", A_CAUSE, 8'h00);
    irq = 8'h00;
    tick(2);
    rst_n = 1'b1;
    tick(2 + SYNC_LAT);
    chk_reg("mrst_pend_quiet", A_PEND, 8'h00);
    pulse_irq(8'h01);
    chk_reg("mrst_pend_fresh", A_PEND, 8'h01);
    tick(3);
    check_eq("mrst_cu_masked", {7'b0, int_cu}, 8'h00);
    io_write(A_PEND, 8'h01);

    // Priority: sources 5 and 2 together
    io_write(A_MASK, 8'hFF);
    pulse_irq(8'h24);
    chk_reg("prio_pend", A_PEND, 8'h24);
    tick(2);
    check_eq("prio_cu_hi", {7'b0, int_cu}, 8'h01);
    chk_reg("prio_cause_req", A_CAUSE, 8'h02);
    ack();
    chk_reg("prio_cause_ack", A_CAUSE, 8'h82);
    chk_reg("prio_pend_ack", A_PEND, 8'h20);
    io_write(A_EOI, 8'h00);
    check_eq("prio_cu_e0", {7'b0, int_cu}, 8'h00);
    tick(1);
    check_eq("prio_cu_e1", {7'b0, int_cu}, 8'h00);
    tick(1);
    check_eq("prio_cu_e2", {7'b0, int_cu}, 8'h01);
    chk_reg("prio_cause_2nd", A_CAUSE, 8'h05);
    ack();
    chk_reg("prio_cause_2nd_ack", A_CAUSE, 8'h85);
    io_write(A_EOI, 8'h00);

    // Masking holds off a pending source until enabled
    io_write(A_MASK, 8'h00);
    pulse_irq(8'h08);
    chk_reg("mask_pend", A_PEND, 8'h08);
    tick(3);
    check_eq("mask_cu_lo", {7'b0, int_cu}, 8'h00);
    io_write(A_MASK, 8'h08);
    check_eq("mask_cu_w0", {7'b0, int_cu}, 8'h00);
    tick(1);
    check_eq("mask_cu_w1", {7'b0, int_cu}, 8'h00);
    tick(1);
    check_eq("mask_cu_w2", {7'b0, int_cu}, 8'h01);
    ack();
    io_write(A_EOI, 8'h00);

    // Withdraw a request by W1C while in REQ
    io_write(A_MASK, 8'h02);
    pulse_irq(8'h02);
    tick(2);
    check_eq("wd_cu_hi", {7'b0, int_cu}, 8'h01);
    io_write(A_PEND, 8'h02);
    tick(1);
    check_eq("wd_cu_lo", {7'b0, int_cu}, 8'h00);
    chk_reg("wd_pend", A_PEND, 8'h00);
    chk_reg("wd_cause", A_CAUSE, 8'h01);
    tick(3);
    check_eq("wd_cu_stay", {7'b0, int_cu}, 8'h00);

    // New edge wins over a same-cycle clear
    io_write(A_MASK, 8'h00);
    irq = 8'h02;
    tick(SYNC_LAT);
    io_write(A_PEND, 8'h02);
    irq = 8'h00;
    chk_reg("setwin_pend", A_PEND, 8'h02);
    io_write(A_PEND, 8'h02);
    chk_reg("setwin_clr", A_PEND, 8'h00);

    // EOI while idle is ignored
    io_write(A_EOI, 8'hFF);
    chk_reg("eoi_idle_cause", A_CAUSE, 8'h01);
    check_eq("eoi_idle_cu", {7'b0, int_cu}, 8'h00);

    // Held IRQ produces a single pending set
    irq = 8'h10;
    tick(1 + SYNC_LAT);
    chk_reg("held_pend", A_PEND, 8'h10);
    io_write(A_PEND, 8'h10);
    tick(18);
    chk_reg("held_no_reset", A_PEND, 8'h00);
    irq = 8'h00;
    tick(2 + SYNC_LAT);

    // Read decode and unmapped accesses
    pulse_irq(8'h10);
    port_id = A_PEND;
    #1;
    check_eq("rd_hit_pend", {7'b0, rd_hit}, 8'h01);
    check_eq("rd_data_pend", in_data, 8'h10);
    port_id = A_EOI;
    #1;
    check_eq("rd_hit_eoi", {7'b0, rd_hit}, 8'h00);
    port_id = 8'h42;
    #1;
    check_eq("rd_hit_unmapped", {7'b0, rd_hit}, 8'h00);
    io_write(8'hE4, 8'hFF);
    chk_reg("unmapped_wr_mask", A_MASK, 8'h00);
    check_eq("unmapped_wr_cu", {7'b0, int_cu}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
